// File: rtl/uart_frame_scheduler_if.sv
// TX byte handshake between the frame scheduler and the byte-level UART TX.
//
// Handshake: tx_start is a one-cycle "valid" pulse the scheduler raises only
// while tx_busy (the TX side's "not ready") is low; tx_data is presented with
// tx_start and held stable until the TX side answers with a one-cycle
// tx_done. A new tx_start never comes before the cycle after tx_done.
interface uart_frame_scheduler_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output tx_start,
      output tx_data,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_start,
      input  tx_data,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Game-state frame scheduler: on each frame tick it snapshots the game
// state and sends a 10-byte frame (header, 8 payload bytes, XOR checksum)
// over the UART TX byte handshake, with a one-deep tick queue, per-byte
// timeout, inter-frame gap and sticky overrun / tx_error flags.
module uart_frame_scheduler #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         GAP_CYCLES     = 16,
   parameter int         TIMEOUT_CYCLES = 65000
) (
   input  logic                   clk65MHz,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   frame_tick,
   input  logic [11:0]            pl1_posx,
   input  logic [11:0]            pl1_posy,
   input  logic [11:0]            ball_xpos,
   input  logic [11:0]            ball_ypos,
   input  logic [3:0]             score_pl1,
   input  logic [3:0]             score_pl2,
   input  logic                   endgame,
   input  logic                   last_touch,
   input  logic                   clr_status,
   uart_frame_scheduler_if.master tx,
   output logic                   frame_busy,
   output logic                   frame_done,
   output logic                   overrun,
   output logic                   tx_error,
   output logic [1:0]             state_o
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   // Last timer value of a byte wait; reaching it without tx_done aborts.
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   // Last gap count; the GAP state always lasts at least one cycle.
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   typedef struct packed {
      logic [11:0] px;
      logic [11:0] py;
      logic [11:0] bx;
      logic [11:0] by;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        last_touch;
      logic        endgame;
   } snap_t;

   state_t         state_q, state_d;
   logic [3:0]     idx_q, idx_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic [GW-1:0]  gap_q, gap_d;
   snap_t          snap_q, snap_d;
   logic           pending_q, pending_d;
   logic           overrun_q, overrun_d;
   logic           tx_error_q, tx_error_d;
   logic           frame_done_q, frame_done_d;

   logic           start_frame;
   logic           issue;
   logic           timeout_evt;
   logic           overrun_evt;
   snap_t          live;
   logic [7:0]     pay1, pay2, pay3, pay4, pay5, pay6, pay7, pay8;
   logic [7:0]     checksum;
   logic [7:0]     frame_byte;

   assign live = '{px: pl1_posx, py: pl1_posy, bx: ball_xpos, by: ball_ypos,
                   s1: score_pl1, s2: score_pl2,
                   last_touch: last_touch, endgame: endgame};

   // Payload bytes are packed from the snapshot only, never the live inputs.
   assign pay1     = snap_q.px[11:4];
   assign pay2     = {snap_q.px[3:0], snap_q.py[11:8]};
   assign pay3     = snap_q.py[7:0];
   assign pay4     = snap_q.bx[11:4];
   assign pay5     = {snap_q.bx[3:0], snap_q.by[11:8]};
   assign pay6     = snap_q.by[7:0];
   assign pay7     = {snap_q.s1, snap_q.s2};
   assign pay8     = {6'b0, snap_q.last_touch, snap_q.endgame};
   assign checksum = pay1 ^ pay2 ^ pay3 ^ pay4 ^ pay5 ^ pay6 ^ pay7 ^ pay8;

   // Select the byte addressed by the current byte index.
   always_comb begin
      frame_byte = 8'h00;
      case (idx_q)
         4'd0:    frame_byte = HEADER;
         4'd1:    frame_byte = pay1;
         4'd2:    frame_byte = pay2;
         4'd3:    frame_byte = pay3;
         4'd4:    frame_byte = pay4;
         4'd5:    frame_byte = pay5;
         4'd6:    frame_byte = pay6;
         4'd7:    frame_byte = pay7;
         4'd8:    frame_byte = pay8;
         4'd9:    frame_byte = checksum;
         default: frame_byte = 8'h00;
      endcase
   end

   // Frame sequencer: next state, byte index, byte timer and gap counter.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      snap_d       = snap_q;
      frame_done_d = 1'b0;
      start_frame  = 1'b0;
      issue        = 1'b0;
      timeout_evt  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((frame_tick || pending_q) && enable) begin
               start_frame = 1'b1;
               snap_d      = live;
               idx_d       = 4'd0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!tx.tx_busy) begin
               issue   = 1'b1;
               timer_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // tx_done is checked first so a reply on the expiry cycle wins.
            if (tx.tx_done) begin
               if (idx_q == 4'd9) begin
                  frame_done_d = 1'b1;
                  gap_d        = '0;
                  state_d      = S_GAP;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_ISSUE;
               end
            end else if (timer_q == TIMER_LAST) begin
               timeout_evt = 1'b1;
               gap_d       = '0;
               state_d     = S_GAP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // One-deep tick queue and sticky status; a set beats a same-cycle clear.
   always_comb begin
      pending_d   = pending_q;
      overrun_evt = 1'b0;
      if (start_frame) begin
         // The request that starts this frame is consumed; a tick that
         // coincides with a queued request stays queued.
         pending_d = pending_q && frame_tick;
      end else if (frame_tick) begin
         if (pending_q) begin
            overrun_evt = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end
      overrun_d  = overrun_evt ? 1'b1 : (clr_status ? 1'b0 : overrun_q);
      tx_error_d = timeout_evt ? 1'b1 : (clr_status ? 1'b0 : tx_error_q);
   end

   // State and datapath registers.
   always_ff @(posedge clk65MHz or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 4'd0;
         timer_q      <= '0;
         gap_q        <= '0;
         snap_q       <= '0;
         pending_q    <= 1'b0;
         overrun_q    <= 1'b0;
         tx_error_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         timer_q      <= timer_d;
         gap_q        <= gap_d;
         snap_q       <= snap_d;
         pending_q    <= pending_d;
         overrun_q    <= overrun_d;
         tx_error_q   <= tx_error_d;
         frame_done_q <= frame_done_d;
      end
   end

   // tx_data is only driven while a byte is being issued or is on the wire.
   assign tx.tx_start = issue;
   assign tx.tx_data  = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? frame_byte : 8'h00;
   assign frame_busy  = (state_q != S_IDLE);
   assign frame_done  = frame_done_q;
   assign overrun     = overrun_q;
   assign tx_error    = tx_error_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed testbench for uart_frame_scheduler: a UART TX responder, a
// scoreboard of expected frame bytes built from the frame-format rules, a
// per-cycle compare process, and directed scenarios with literal timing.
`timescale 1ns/1ps
module tb_uart_frame_scheduler;

   localparam int GAP = 16;
   localparam int TMO = 100;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        enable     = 1'b0;
   logic        frame_tick = 1'b0;
   logic        clr_status = 1'b0;
   logic [11:0] pl1_posx   = '0;
   logic [11:0] pl1_posy   = '0;
   logic [11:0] ball_xpos  = '0;
   logic [11:0] ball_ypos  = '0;
   logic [3:0]  score_pl1  = '0;
   logic [3:0]  score_pl2  = '0;
   logic        endgame    = 1'b0;
   logic        last_touch = 1'b0;
   logic        frame_busy, frame_done, overrun, tx_error;
   logic [1:0]  state_dbg;

   logic resp_busy  = 1'b0;
   logic bp_busy    = 1'b0;
   logic resp_done  = 1'b0;
   logic stray_done = 1'b0;

   uart_frame_scheduler_if txi();
   assign txi.tx_busy = resp_busy | bp_busy;
   assign txi.tx_done = resp_done | stray_done;

   uart_frame_scheduler #(
      .HEADER         (8'hA5),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk65MHz   (clk),
      .rst        (rst_n),
      .enable     (enable),
      .frame_tick (frame_tick),
      .pl1_posx   (pl1_posx),
      .pl1_posy   (pl1_posy),
      .ball_xpos  (ball_xpos),
      .ball_ypos  (ball_ypos),
      .score_pl1  (score_pl1),
      .score_pl2  (score_pl2),
      .endgame    (endgame),
      .last_touch (last_touch),
      .clr_status (clr_status),
      .tx         (txi),
      .frame_busy (frame_busy),
      .frame_done (frame_done),
      .overrun    (overrun),
      .tx_error   (tx_error),
      .state_o    (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];   // {last_byte_of_frame, byte}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Frame model: header, packed positions, scores, flags, XOR of payload.
   function automatic void push_cur();
      int b [10];
      int x;
      b[0] = 'hA5;
      b[1] = int'(pl1_posx) / 16;
      b[2] = (int'(pl1_posx) % 16) * 16 + int'(pl1_posy) / 256;
      b[3] = int'(pl1_posy) % 256;
      b[4] = int'(ball_xpos) / 16;
      b[5] = (int'(ball_xpos) % 16) * 16 + int'(ball_ypos) / 256;
      b[6] = int'(ball_ypos) % 256;
      b[7] = int'(score_pl1) * 16 + int'(score_pl2);
      b[8] = int'(last_touch) * 2 + int'(endgame);
      x = 0;
      for (int i = 1; i <= 8; i++) x = x ^ b[i];
      b[9] = x;
      for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), 8'(b[i])});
   endfunction

   function automatic void push_literal(input logic [79:0] v);
      for (int i = 0; i < 10; i++) exp_q.push_back({(i == 9), v[79-8*i -: 8]});
   endfunction

   // ---------------- TX responder ----------------
   int resp_delay = 20;
   int hang_idx   = -1;
   int n_starts   = 0;

   initial begin : responder
      forever begin
         @(negedge clk);
         if (txi.tx_start && rst_n) begin
            n_starts++;
            if (n_starts - 1 != hang_idx) begin
               @(posedge clk);
               #1 resp_busy = 1'b1;
               repeat (resp_delay - 1) @(posedge clk);
               #1 resp_busy = 1'b0;
               resp_done = 1'b1;
               @(posedge clk);
               #1 resp_done = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [8:0] cur_e;
   logic [7:0] cur_byte  = '0;
   bit         cur_last  = 1'b0;
   bit         in_flight = 1'b0;
   bit         fd_expect = 1'b0;
   bit         fd_next;
   bit         chk_hold  = 1'b1;

   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_flight = 1'b0;
            fd_expect = 1'b0;
         end else begin
            check("frame_done", frame_done, fd_expect);
            fd_next = 1'b0;
            if (txi.tx_done && in_flight) begin
               in_flight = 1'b0;
               fd_next   = cur_last;
            end
            if (txi.tx_start) begin
               check("start_while_busy", txi.tx_busy, 0);
               if (exp_q.size() == 0) begin
                  fail("unexpected_tx_start");
               end else begin
                  cur_e = exp_q.pop_front();
                  check("tx_data", txi.tx_data, cur_e[7:0]);
                  cur_byte  = cur_e[7:0];
                  cur_last  = cur_e[8];
                  in_flight = 1'b1;
               end
            end else if (in_flight && resp_busy && chk_hold) begin
               check("tx_data_hold", txi.tx_data, cur_byte);
            end
            fd_expect = fd_next;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < max_cycles; k++) begin
         @(negedge clk);
         if (!frame_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail("wait_idle_timeout");
      step();
   endtask

   task automatic set_inputs(input logic [11:0] px, py, bx, by,
                             input logic [3:0] s1, s2, input logic eg, lt);
      pl1_posx = px; pl1_posy = py; ball_xpos = bx; ball_ypos = by;
      score_pl1 = s1; score_pl2 = s2; endgame = eg; last_touch = lt;
   endtask

   // ---------------- watchdog ----------------
   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed scenarios ----------------
   initial begin : main_seq
      int  busy_cnt, fd_cnt, gap_cnt, cnt, starts;
      bit  hit;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_tx_start", txi.tx_start, 0);
      check("rst_tx_data", txi.tx_data, 0);
      check("rst_frame_busy", frame_busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("rst_tx_error", tx_error, 0);
      step();
      rst_n = 1'b1;
      step();
      enable = 1'b1;
      step();

      // Single frame with literal bytes, latency and frame/gap length
      set_inputs(12'h123, 12'h456, 12'h789, 12'hABC, 4'd3, 4'd5, 1'b1, 1'b0);
      push_literal(80'hA5_12_34_56_78_9A_BC_35_01_1A);
      tick();
      @(negedge clk);
      check("first_start_latency", txi.tx_start, 1);
      busy_cnt = 1; fd_cnt = 0; gap_cnt = 0; hit = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (!frame_busy) begin
            hit = 1'b1;
            break;
         end
         busy_cnt++;
         if (frame_done) begin
            fd_cnt++;
            gap_cnt = 0;
         end
         if (fd_cnt > 0) gap_cnt++;
      end
      if (!hit) fail("single_frame_timeout");
      check("frame_busy_cycles", busy_cnt, 226);
      check("frame_done_count", fd_cnt, 1);
      check("gap_cycles", gap_cnt, GAP);
      check("single_exp_empty", exp_q.size(), 0);
      step();

      // Snapshot stability: inputs change mid-frame
      set_inputs(12'hFED, 12'h0F0, 12'h001, 12'h800, 4'd9, 4'hF, 1'b0, 1'b1);
      push_cur();
      tick();
      repeat (50) step();
      set_inputs(12'h5A5, 12'hC3C, 12'h7E1, 12'h02F, 4'd1, 4'd8, 1'b1, 1'b1);
      wait_idle(1000);
      push_cur();
      tick();
      wait_idle(1000);

      // One queued tick: second frame right after the gap, snapshot at start
      push_cur();
      tick();
      repeat (100) step();
      tick();
      set_inputs(12'h0AB, 12'hCDE, 12'h321, 12'h654, 4'd7, 4'd2, 1'b0, 1'b0);
      push_cur();
      hit = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (frame_done) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail("queue_frame_done_timeout");
      cnt = 0; hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         cnt++;
         if (txi.tx_start) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail("queue_restart_timeout");
      check("queued_restart_delay", cnt, GAP + 1);
      wait_idle(1000);
      check("queue1_overrun", overrun, 0);

      // Two ticks during a frame: one extra frame, overrun set
      push_cur();
      tick();
      repeat (60) step();
      tick();
      repeat (30) step();
      tick();
      @(negedge clk);
      check("overrun_set", overrun, 1);
      step();
      push_cur();
      wait_idle(1500);
      repeat (40) step();
      @(negedge clk);
      check("no_third_frame", frame_busy, 0);
      step();
      pulse_clr();
      @(negedge clk);
      check("overrun_cleared", overrun, 0);
      step();

      // Timeout on B3: abort, no frame_done, sticky tx_error
      hang_idx = n_starts + 3;
      push_cur();
      tick();
      starts = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (txi.tx_start) starts++;
         if (starts == 4) break;
      end
      check("timeout_starts_before_hang", starts, 4);
      cnt = 0; hit = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         cnt++;
         if (tx_error) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail("tx_error_timeout");
      check("tx_error_delay", cnt, TMO + 1);
      check("aborted_bytes_left", exp_q.size(), 6);
      exp_q.delete();
      step();
      wait_idle(200);
      hang_idx = -1;
      push_cur();
      tick();
      wait_idle(1000);
      check("tx_error_sticky", tx_error, 1);
      pulse_clr();
      @(negedge clk);
      check("tx_error_cleared", tx_error, 0);
      step();

      // Backpressure: tx_busy high for 50 cycles at the tick
      set_inputs(12'h111, 12'h222, 12'h333, 12'h444, 4'd4, 4'd4, 1'b1, 1'b0);
      push_cur();
      bp_busy = 1'b1;
      tick();
      repeat (49) step();
      bp_busy = 1'b0;
      @(negedge clk);
      check("start_after_busy_release", txi.tx_start, 1);
      wait_idle(1000);

      // Stray tx_done in IDLE is ignored
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      repeat (5) step();
      @(negedge clk);
      check("stray_done_ignored", frame_busy, 0);
      step();

      // enable=0 blocks the frame; raising enable starts the pending one
      enable = 1'b0;
      tick();
      repeat (30) step();
      @(negedge clk);
      check("disabled_no_frame", frame_busy, 0);
      step();
      set_inputs(12'h9F0, 12'h0F9, 12'hE0E, 12'h1D1, 4'd0, 4'd12, 1'b0, 1'b1);
      push_cur();
      enable = 1'b1;
      @(negedge clk);
      check("enable_same_cycle_no_start", txi.tx_start, 0);
      @(negedge clk);
      check("enable_pending_start", txi.tx_start, 1);
      wait_idle(1000);

      // Async reset mid-frame at B5
      push_cur();
      tick();
      starts = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (txi.tx_start) starts++;
         if (starts == 6) break;
      end
      check("reset_reached_b5", starts, 6);
      #2;
      chk_hold = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("arst_tx_start", txi.tx_start, 0);
      check("arst_tx_data", txi.tx_data, 0);
      check("arst_frame_busy", frame_busy, 0);
      check("arst_frame_done", frame_done, 0);
      check("arst_overrun", overrun, 0);
      check("arst_tx_error", tx_error, 0);
      exp_q.delete();
      repeat (3) step();
      rst_n = 1'b1;
      for (int k = 0; k < 100 && resp_busy; k++) step();
      chk_hold = 1'b1;
      repeat (60) step();
      @(negedge clk);
      check("no_start_after_reset", frame_busy, 0);
      step();
      push_cur();
      tick();
      wait_idle(1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
- Sequences transmission of the game-state snapshot to the peer board over the UART transmitter, one 10-byte frame per frame tick.
- Sits between the game logic (player/ball positions, scores, flags) and the byte-level UART TX inside the UART top.
- Owns the TX byte handshake, frame framing and checksum, one-deep tick queuing, per-byte timeout and sticky error status.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- GAP_CYCLES, 16, idle clocks forced between the end of one frame and the start of the next.
- TIMEOUT_CYCLES, 65000, max clocks to wait for tx_done after a tx_start; must be >= 1.

Ports:
- clk65MHz  input  1  system pixel/logic clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  level; 0 blocks the start of new frames (a frame in progress completes).
- frame_tick  input  1  one-cycle pulse requesting a frame (once per video frame).
- pl1_posx, pl1_posy  input  12 each  local player position.
- ball_xpos, ball_ypos  input  12 each  ball position.
- score_pl1, score_pl2  input  4 each  scores.
- endgame, last_touch  input  1 each  game flags.
- clr_status  input  1  one-cycle pulse clearing the sticky flags.
- tx_busy  input  1  UART TX is shifting.
- tx_done  input  1  one-cycle pulse, byte fully sent.
- tx_start  output  1  one-cycle pulse, load tx_data.
- tx_data  output  8  byte to send; held stable from tx_start until tx_done.
- frame_busy  output  1  high from snapshot until return to IDLE.
- frame_done  output  1  one-cycle pulse after the last byte's tx_done.
- overrun  output  1  sticky; a tick was lost.
- tx_error  output  1  sticky; timeout abort occurred.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, pending=0, counters 0, snapshot 0.
- States and transitions:
  - IDLE: leaves when (frame_tick or pending) and enable. On that edge: latch all inputs into the snapshot, clear pending, go to ISSUE.
  - ISSUE: waits while tx_busy=1. When tx_busy=0: tx_start=1 for exactly one cycle, tx_data=current byte, timer reset, go to WAIT.
  - WAIT: on tx_done:
    - byte index < 9: index+1, go to ISSUE (next tx_start no earlier than one cycle after tx_done).
    - byte index = 9: frame_done pulse next cycle, go to GAP.
  - WAIT timeout: timer reaching TIMEOUT_CYCLES without tx_done sets tx_error, aborts the frame, goes to GAP. No frame_done.
  - GAP: counts GAP_CYCLES, then goes to IDLE.
- Latency: tick in IDLE at cycle N gives the snapshot at edge N and the first tx_start in cycle N+1 if tx_busy=0.
- Frame layout, taken from the snapshot only (inputs may change mid-frame):
  - B0 = HEADER.
  - B1 = posx[11:4]; B2 = {posx[3:0], posy[11:8]}; B3 = posy[7:0]. All from pl1.
  - B4..B6 = the same packing for ball_xpos/ball_ypos.
  - B7 = {score_pl1, score_pl2}.
  - B8 = {6'b0, last_touch, endgame}.
  - B9 = XOR of B1..B8. HEADER is excluded.
- Tick handling outside IDLE, or while enable=0:
  - If pending=0: set pending.
  - If pending=1: set overrun. The queue is one deep.
- Tick arriving in the same cycle as the return to IDLE: counted as a pending request, not lost.
- tx_done outside WAIT: ignored.
- tx_done in the same cycle as timeout expiry: tx_done wins, no error.
- clr_status clears overrun and tx_error. A set event in the same cycle wins over the clear.
- frame_busy = (state != IDLE).
- Width rules: byte index is 4 bits, valid 0..9. Timer width is $clog2(TIMEOUT_CYCLES+1). Gap counter width is $clog2(GAP_CYCLES+1).

Test Plan:
- Single frame: pl1=(0x123,0x456), ball=(0x789,0xABC), scores 3/5, endgame=1, last_touch=0, TX model responds with tx_done 20 cycles after tx_start -> bytes A5,12,34,56,78,9A,BC,35,01,1A. Then one frame_done pulse and GAP_CYCLES idle clocks.
- Snapshot stability: change all inputs after the tick, mid-frame -> all bytes still match the values at tick time. The next frame carries the new values.
- Queuing: 1 tick during a frame -> second frame starts right after GAP, overrun=0. 2 ticks during a frame -> exactly one extra frame, overrun=1. clr_status -> overrun=0.
- Timeout: TX model never asserts tx_done on B3 -> tx_error=1 after TIMEOUT_CYCLES, no frame_done, return to IDLE. The next tick sends a full frame starting with A5.
- Backpressure/enable: tx_busy held high for 50 cycles at tick -> tx_start is delayed until tx_busy=0. enable=0 with a tick -> no frame. enable raised -> the pending frame starts.
- Async reset mid-frame at B5: all outputs 0 immediately. After release, no tx_start until a new tick.
